// File: rtl/ram_port_master.sv
// ram_port_master: burst read/write sequencer for one dual-port RAM port with read-latency-aligned return data
module ram_port_master #(
  parameter int AW = 9,
  parameter int DW = 8,
  parameter int DEPTH = 512,
  parameter int LW = 4,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic          wd_valid,
  output logic          wd_ready,
  input  logic [DW-1:0] wd_data,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          done,
  output logic          err,
  output logic          wren,
  output logic          rden,
  output logic [AW-1:0] address,
  output logic [DW-1:0] data,
  input  logic [DW-1:0] q
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
  localparam logic [AW:0] depth_w = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] top = AW'(DEPTH-1);
  state_t state;
  logic [AW-1:0] cur_addr;
  logic [LW-1:0] cnt;
  logic [RD_LAT:0] vld, lst;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a);
    return a == top ? '0 : a + 1'b1;
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cmd_ready <= 1'b1;
      wd_ready <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= '0;
      rd_last <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      wren <= 1'b0;
      rden <= 1'b0;
      address <= '0;
      data <= '0;
      cur_addr <= '0;
      cnt <= '0;
      vld <= '0;
      lst <= '0;
    end else begin
      wren <= 1'b0;
      rden <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      vld <= {vld[RD_LAT-1:0], 1'b0};
      lst <= {lst[RD_LAT-1:0], 1'b0};
      rd_valid <= vld[RD_LAT];
      rd_last <= lst[RD_LAT];
      if (vld[RD_LAT]) rd_data <= q;
      case (state)
        IDLE: if (cmd_valid) begin
          cmd_ready <= 1'b0;
          cnt <= cmd_len;
          if ({1'b0, cmd_addr} >= depth_w) begin
            state <= DONE;
            done <= 1'b1;
            err <= 1'b1;
          end else if (cmd_write) begin
            state <= WRITE;
            wd_ready <= 1'b1;
            cur_addr <= cmd_addr;
          end else begin
            state <= READ;
            rden <= 1'b1;
            address <= cmd_addr;
            cur_addr <= nxt(cmd_addr);
            vld[0] <= 1'b1;
            lst[0] <= cmd_len == '0;
          end
        end
        WRITE: if (wd_valid) begin
          wren <= 1'b1;
          address <= cur_addr;
          data <= wd_data;
          cur_addr <= nxt(cur_addr);
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            wd_ready <= 1'b0;
            state <= DRAIN;
          end
        end
        READ: if (cnt == '0) begin
          state <= DRAIN;
        end else begin
          rden <= 1'b1;
          address <= cur_addr;
          cur_addr <= nxt(cur_addr);
          cnt <= cnt - 1'b1;
          vld[0] <= 1'b1;
          lst[0] <= cnt == LW'(1);
        end
        DRAIN: if (vld == '0) begin
          state <= DONE;
          done <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_port_master.sv
// tb_ram_port_master: randomized checks of two sequencer instances against a queue-based transaction model
module tb_ram_port_master;
  logic clk = 1'b0, rst = 1'b1, fill = 1'b1;
  int act = 0;
  logic [1:0] cmd_valid = '0, cmd_write = '0, wd_valid = '0;
  logic [8:0] cmd_addr [2];
  logic [3:0] cmd_len [2];
  logic [7:0] wd_data [2];
  wire [1:0] cmd_ready, wd_ready, rd_valid, rd_last, done, err, wren, rden;
  wire [8:0] address [2];
  wire [7:0] rd_data [2], data [2], q [2];
  logic [7:0] ref_mem [2][512];
  logic [7:0] wdat [$];
  logic [16:0] exp_wr [$];
  logic [8:0] exp_ra [$];
  logic [8:0] exp_rd [$];
  logic exp_done [$];
  int st [$];
  int checks = 0, failures = 0, cyc = 0;
  int busy = 0, acc_cyc = 0, done_cyc = 0, last_evt = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int D = g ? 320 : 512;
    localparam int L = g ? 3 : 1;
    logic [7:0] mem [D];
    logic [7:0] qp [L];
    ram_port_master #(.AW(9), .DW(8), .DEPTH(D), .LW(4), .RD_LAT(L)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_write(cmd_write[g]),
      .cmd_addr(cmd_addr[g]), .cmd_len(cmd_len[g]),
      .wd_valid(wd_valid[g]), .wd_ready(wd_ready[g]), .wd_data(wd_data[g]),
      .rd_valid(rd_valid[g]), .rd_data(rd_data[g]), .rd_last(rd_last[g]),
      .done(done[g]), .err(err[g]), .wren(wren[g]), .rden(rden[g]),
      .address(address[g]), .data(data[g]), .q(q[g])
    );
    always @(posedge clk) begin
      qp[0] <= rden[g] ? mem[address[g]] : 8'h00;
      for (int k = 1; k < L; k++) qp[k] <= qp[k-1];
      if (fill) for (int i = 0; i < D; i++) mem[i] <= 8'(i) ^ 8'hA5;
      else if (wren[g]) mem[address[g]] <= data[g];
    end
    assign q[g] = qp[L-1];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  task automatic rst_vals(input int g);
    chk("rst_vals", {cmd_ready[g], wd_ready[g], rd_valid[g], rd_last[g], done[g], err[g], wren[g], rden[g]}, 8'h80);
    chk("rst_bus", {address[g], data[g], rd_data[g]}, 0);
  endtask
  task automatic cmd(input bit w, input int addr, input int len);
    int dep = act ? 320 : 512;
    int a;
    bit acc = 0;
    cmd_valid[act] = 1'b1;
    cmd_write[act] = w;
    cmd_addr[act] = 9'(addr);
    cmd_len[act] = 4'(len);
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = cmd_ready[act];
      @(posedge clk);
      #1;
    end
    cmd_valid[act] = 1'b0;
    chk("cmd_accept", acc, 1);
    if (!acc) return;
    if (addr >= dep) begin
      exp_done.push_back(1'b1);
      return;
    end
    for (int i = 0; i <= len; i++) begin
      a = (addr + i) % dep;
      if (w) begin
        exp_wr.push_back({9'(a), wdat[i]});
        ref_mem[act][a] = wdat[i];
      end else begin
        exp_ra.push_back(9'(a));
        exp_rd.push_back({i == len, ref_mem[act][a]});
      end
    end
    exp_done.push_back(1'b0);
  endtask
  task automatic beats(input int n, input int gap, input bit rg);
    bit ok;
    for (int i = 0; i < n; i++) begin
      wd_valid[act] = 1'b1;
      wd_data[act] = wdat[i];
      ok = 0;
      for (int t = 0; t < 50 && !ok; t++) begin
        @(negedge clk);
        ok = wd_ready[act];
        @(posedge clk);
        #1;
      end
      chk("wd_accept", ok, 1);
      if (i == gap || (rg && $urandom_range(3) == 0)) begin
        wd_valid[act] = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    wd_valid[act] = 1'b0;
  endtask
  task automatic wait_done();
    for (int t = 0; t < 200 && busy != 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk("done_wait", busy, 0);
  endtask
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    int o, lat, s;
    logic [16:0] ew;
    logic [8:0] er;
    logic ed;
    forever begin
      @(negedge clk);
      if (!rst) begin
        o = 1 - act;
        lat = act ? 3 : 1;
        chk("idle_other", {cmd_ready[o], wd_ready[o], rd_valid[o], wren[o], rden[o], done[o]}, 6'b100000);
        chk("ready", cmd_ready[act], busy == 0);
        chk("excl", wren[act] & rden[act], 0);
        chk("err_done", err[act] & ~done[act], 0);
        if (wren[act]) begin
          chk("wr_pending", exp_wr.size() > 0, 1);
          if (exp_wr.size() > 0) begin
            ew = exp_wr.pop_front();
            chk("wr_addr", address[act], ew[16:8]);
            chk("wr_data", data[act], ew[7:0]);
          end
          last_evt = cyc;
        end
        if (rden[act]) begin
          chk("rd_pending", exp_ra.size() > 0, 1);
          if (exp_ra.size() > 0) chk("rd_addr", address[act], exp_ra.pop_front());
          st.push_back(cyc);
        end
        if (rd_valid[act]) begin
          chk("rv_pending", exp_rd.size() > 0 && st.size() > 0, 1);
          if (exp_rd.size() > 0 && st.size() > 0) begin
            er = exp_rd.pop_front();
            s = st.pop_front();
            chk("rd_data", rd_data[act], er[7:0]);
            chk("rd_last", rd_last[act], er[8]);
            chk("rd_lat", cyc - s, lat + 1);
          end
          last_evt = cyc;
        end
        if (done[act]) begin
          chk("done_pending", exp_done.size() > 0, 1);
          if (exp_done.size() > 0) begin
            ed = exp_done.pop_front();
            chk("err", err[act], ed);
            if (ed) chk("err_time", cyc - acc_cyc, 1);
            else chk("done_time", cyc - last_evt, 1);
            chk("done_left", exp_wr.size() + exp_ra.size() + exp_rd.size(), 0);
          end
          done_cyc = cyc;
          busy = 0;
        end
        if (cmd_valid[act] && cmd_ready[act]) begin
          busy = 1;
          acc_cyc = cyc;
        end
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    int w, addr, len, dep;
    for (int g = 0; g < 2; g++) begin
      cmd_addr[g] = '0;
      cmd_len[g] = '0;
      wd_data[g] = '0;
      for (int i = 0; i < 512; i++) ref_mem[g][i] = 8'(i) ^ 8'hA5;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    fill = 1'b0;
    @(negedge clk);
    rst_vals(0);
    rst_vals(1);
    @(posedge clk);
    #1;
    act = 0;
    cmd(0, 0, 15);
    wait_done();
    act = 1;
    cmd(0, 0, 15);
    wait_done();
    act = 0;
    wdat = '{8'h90};
    cmd(1, 10, 0);
    beats(1, -1, 0);
    wait_done();
    cmd(0, 10, 0);
    wait_done();
    wdat = '{8'h11, 8'h22, 8'h33, 8'h44};
    cmd(1, 510, 3);
    beats(4, 1, 0);
    wait_done();
    chk("wr_dur", done_cyc - acc_cyc, 7);
    cmd(0, 510, 3);
    wait_done();
    act = 1;
    cmd(1, 320, 0);
    wait_done();
    cmd(0, 400, 2);
    wait_done();
    cmd(0, 319, 1);
    wait_done();
    act = 0;
    wdat = '{8'(8'h3C), 8'hC3, 8'h5A, 8'hA5};
    cmd(1, 100, 3);
    cmd_valid[0] = 1'b1;
    cmd_write[0] = 1'b0;
    cmd_addr[0] = 9'd100;
    cmd_len[0] = 4'd3;
    beats(4, -1, 0);
    cmd(0, 100, 3);
    chk("hold_gap", acc_cyc - done_cyc, 1);
    wait_done();
    cmd(0, 40, 7);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    exp_wr.delete();
    exp_ra.delete();
    exp_rd.delete();
    exp_done.delete();
    st.delete();
    busy = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    rst_vals(0);
    repeat (10) @(posedge clk);
    #1;
    wdat = '{8'h5A};
    cmd(1, 40, 0);
    beats(1, -1, 0);
    wait_done();
    cmd(0, 40, 0);
    wait_done();
    for (int g = 0; g < 2; g++) begin
      act = g;
      dep = g ? 320 : 512;
      for (int j = 0; j < 25; j++) begin
        w = $urandom_range(1);
        len = $urandom_range(15);
        addr = (g == 1 && $urandom_range(7) == 0) ? $urandom_range(511, 320) : $urandom_range(dep - 1);
        wdat.delete();
        for (int i = 0; i <= len; i++) wdat.push_back(8'($urandom));
        cmd(w[0], addr, len);
        if (w == 1 && addr < dep) beats(len + 1, -1, 1);
        wait_done();
      end
    end
    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
